memory_bank_config_writer: RTL and testbench
============================================

MEMORY_BANK_CONFIG_WRITER -- requirements
Module: memory_bank_config_writer

Interface
REQ-001 Parameter BL_WIDTH, default 3: number of bit lines driven; this is the data width of one configuration row.
REQ-002 Parameter WL_WIDTH, default 3: number of word lines, which is also the number of rows per load.
REQ-003 Parameters SETUP_CYC, PULSE_CYC and HOLD_CYC, defaults 1, 2 and 1: bl-to-wl setup, wl pulse width and wl-to-bl hold times, in cycles; each is at least 1.
REQ-004 prog_clk  input  1  programming clock; all state updates on its rising edge.
REQ-005 prog_reset_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  one-cycle request to begin a full bank load.
REQ-007 abort  input  1  cancels the load in progress.
REQ-008 cfg_valid  input  1  row data offered.
REQ-009 cfg_ready  output  1  writer can accept a row.
REQ-010 cfg_data  input  BL_WIDTH  row data; bit i maps to bl[i].
REQ-011 bl  output  [0:BL_WIDTH-1]  bit lines to the tile bank.
REQ-012 wl  output  [0:WL_WIDTH-1]  word lines to the tile bank, at most one hot.
REQ-013 busy  output  1  a load is in progress.
REQ-014 done  output  1  the last load completed; sticky.

Function
REQ-015 All outputs are registered, and every output resets to 0.
REQ-016 The FSM states are IDLE, LOAD, SETUP, PULSE, HOLD and DONE.
REQ-017 IDLE: cfg_ready=0, bl=0, wl=0, busy=0; start=1 moves to LOAD, clears done and sets row=0.
REQ-018 LOAD: cfg_ready=1, wl=0; a transfer occurs on cfg_valid&cfg_ready; at that edge bl takes cfg_data and the FSM moves to SETUP.
REQ-019 SETUP lasts SETUP_CYC cycles with wl=0 and bl held.
REQ-020 PULSE lasts PULSE_CYC cycles with wl[row]=1, all other wl=0, and bl held.
REQ-021 HOLD lasts HOLD_CYC cycles with wl=0 and bl held.
REQ-022 At the end of HOLD: if row==WL_WIDTH-1, go to DONE; otherwise increment row and return to LOAD.
REQ-023 DONE lasts one cycle with bl=0 and sets done=1; the FSM then returns to IDLE.
REQ-024 busy=1 in every state except IDLE and DONE.
REQ-025 Minimum row period is 1+SETUP_CYC+PULSE_CYC+HOLD_CYC cycles (5 with defaults); cfg_valid low in LOAD stalls indefinitely with no output change.
REQ-026 start while busy is ignored.
REQ-027 cfg_valid outside LOAD is ignored and no data is captured.
REQ-028 abort in any busy state returns to IDLE at the next edge: wl=0, bl=0, done unchanged (stays 0).
REQ-029 abort takes priority over a simultaneous handshake or phase completion.
REQ-030 start and abort asserted together in IDLE: abort wins and the FSM stays in IDLE.
REQ-031 The row counter is max(1,$clog2(WL_WIDTH)) bits and never exceeds WL_WIDTH-1.
REQ-032 The phase counter is sized to max(SETUP_CYC,PULSE_CYC,HOLD_CYC).
REQ-033 wl is never asserted in the same cycle that bl changes.

Reset
REQ-034 Asserting prog_reset_n low immediately forces state IDLE and zeroes row, the phase counter, bl, wl, cfg_ready, busy and done, independent of prog_clk.
REQ-035 Reset asserted during PULSE drops wl asynchronously; no partial word line pulse continues.
REQ-036 Deasserting reset leaves the FSM in IDLE; no load starts without a new start pulse.

Structure
REQ-037 A shared package memory_bank_pkg holds the FSM state enum and the default BL_WIDTH, WL_WIDTH and cycle constants.
REQ-038 One sub-module, memory_bank_phase_timer, is used: a loadable down-counter with an expire flag, shared by SETUP, PULSE and HOLD.

Verification
REQ-039 Defaults; start, then rows 3'b101, 3'b011, 3'b110 with cfg_valid held high -> wl[0], wl[1] and wl[2] each high for exactly 2 cycles with bl equal to the matching row; done=1 one cycle after the last HOLD cycle; total 15 busy cycles.
REQ-040 Delay cfg_valid for 4 cycles before row 1 -> cfg_ready stays high, bl and wl stay 0 through the stall, and the row-1 timing after the handshake is unchanged.
REQ-041 abort asserted in the second PULSE cycle of row 1 -> at the next edge wl=0, bl=0, busy=0 and done=0; a following start reloads beginning at row 0.
REQ-042 prog_reset_n pulsed low mid-PULSE, asynchronous to prog_clk -> wl drops without waiting for a clock edge and all outputs read 0; no activity occurs after release until start.
REQ-043 start pulsed during row 1 and cfg_valid pulsed in IDLE -> no effect on the FSM, and bl does not change.
REQ-044 Checker runs on all tests: wl is at most one hot, bl is stable whenever wl is nonzero, and bl and wl never change on the same edge.

Source files
------------

// File: rtl/memory_bank_pkg.sv
// Shared definitions for the memory bank configuration writer.
// Holds the default geometry and timing, the FSM state encoding and a
// small sizing helper used by the top level.
package memory_bank_pkg;

    localparam int BL_WIDTH_DEF  = 3;
    localparam int WL_WIDTH_DEF  = 3;
    localparam int SETUP_CYC_DEF = 1;
    localparam int PULSE_CYC_DEF = 2;
    localparam int HOLD_CYC_DEF  = 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SETUP = 3'd2,
        ST_PULSE = 3'd3,
        ST_HOLD  = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/memory_bank_phase_timer.sv
// Loadable down-counter shared by the SETUP, PULSE and HOLD phases.
// Ports:
//   prog_clk, prog_reset_n : clock, async active-low reset
//   load_i, load_val_i     : load the counter (phase length minus one)
//   expire_o               : counter has reached zero (last cycle of phase)
module memory_bank_phase_timer #(
    parameter int CNT_W = 1
) (
    input  logic             prog_clk,
    input  logic             prog_reset_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             expire_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/memory_bank_config_writer.sv
// Writes a full configuration bank row by row: each row is captured over a
// valid/ready handshake, driven on the bit lines, then the row's word line is
// pulsed with setup and hold margins around it.
// Ports:
//   prog_clk, prog_reset_n : clock, async active-low reset
//   start, abort           : begin a bank load / cancel the load in progress
//   cfg_valid, cfg_ready   : row data handshake
//   cfg_data               : row data, bit i drives bl[i]
//   bl, wl                 : bit lines and word lines to the tile bank
//   busy, done             : load in progress / last load completed (sticky)
//
// state | meaning
// IDLE  | waiting for start, lines released
// LOAD  | ready for the next row's data
// SETUP | bit lines settling before the word line pulse
// PULSE | word line of the current row asserted
// HOLD  | bit lines held after the word line drops
// DONE  | one-cycle completion, sets done
module memory_bank_config_writer
    import memory_bank_pkg::*;
#(
    parameter int BL_WIDTH  = BL_WIDTH_DEF,
    parameter int WL_WIDTH  = WL_WIDTH_DEF,
    parameter int SETUP_CYC = SETUP_CYC_DEF,
    parameter int PULSE_CYC = PULSE_CYC_DEF,
    parameter int HOLD_CYC  = HOLD_CYC_DEF
) (
    input  logic                prog_clk,
    input  logic                prog_reset_n,
    input  logic                start,
    input  logic                abort,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [BL_WIDTH-1:0] cfg_data,
    output logic [0:BL_WIDTH-1] bl,
    output logic [0:WL_WIDTH-1] wl,
    output logic                busy,
    output logic                done
);

    localparam int ROW_W  = (WL_WIDTH > 1) ? $clog2(WL_WIDTH) : 1;
    localparam int PH_MAX = max3(SETUP_CYC, PULSE_CYC, HOLD_CYC);
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(WL_WIDTH - 1);

    state_e              state_q, state_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [BL_WIDTH-1:0] bl_q, bl_d;
    logic [WL_WIDTH-1:0] wl_q, wl_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                capture;
    logic                timer_load;
    logic [PH_W-1:0]     timer_val;
    logic                timer_expire;

    memory_bank_phase_timer #(
        .CNT_W(PH_W)
    ) u_phase_timer (
        .prog_clk    (prog_clk),
        .prog_reset_n(prog_reset_n),
        .load_i      (timer_load),
        .load_val_i  (timer_val),
        .expire_o    (timer_expire)
    );

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        done_d     = done_q;
        capture    = 1'b0;
        timer_load = 1'b0;
        timer_val  = '0;
        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d = ST_LOAD;
                    row_d   = '0;
                    done_d  = 1'b0;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (cfg_valid && ready_q) begin
                    state_d    = ST_SETUP;
                    capture    = 1'b1;
                    timer_load = 1'b1;
                    timer_val  = PH_W'(SETUP_CYC - 1);
                end
            end
            ST_SETUP: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (timer_expire) begin
                    state_d    = ST_PULSE;
                    timer_load = 1'b1;
                    timer_val  = PH_W'(PULSE_CYC - 1);
                end
            end
            ST_PULSE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (timer_expire) begin
                    state_d    = ST_HOLD;
                    timer_load = 1'b1;
                    timer_val  = PH_W'(HOLD_CYC - 1);
                end
            end
            ST_HOLD: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (timer_expire) begin
                    if (row_q == LAST_ROW) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_LOAD;
                        row_d   = row_q + ROW_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are derived from the next state so they come straight off flops.
        ready_d = (state_d == ST_LOAD);
        busy_d  = (state_d inside {ST_LOAD, ST_SETUP, ST_PULSE, ST_HOLD});
        if (state_d == ST_DONE) begin
            done_d = 1'b1;
        end

        wl_d = '0;
        if (state_d == ST_PULSE) begin
            wl_d[row_q] = 1'b1;
        end

        // Bit lines only carry data across SETUP/PULSE/HOLD; they are released
        // while waiting for a row so no stale pattern sits on the bank.
        bl_d = '0;
        if (state_d inside {ST_SETUP, ST_PULSE, ST_HOLD}) begin
            bl_d = capture ? cfg_data : bl_q;
        end
    end

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            bl_q    <= '0;
            wl_q    <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            bl_q    <= bl_d;
            wl_q    <= wl_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Line outputs are declared ascending; map by index so bit i lands on line i.
    always_comb begin
        for (int i = 0; i < BL_WIDTH; i++) begin
            bl[i] = bl_q[i];
        end
        for (int j = 0; j < WL_WIDTH; j++) begin
            wl[j] = wl_q[j];
        end
    end

    assign cfg_ready = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_memory_bank_config_writer.sv
module tb_memory_bank_config_writer;

    logic       prog_clk = 1'b0;
    logic       prog_reset_n;
    logic       start;
    logic       abort;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [2:0] cfg_data;
    logic [0:2] bl;
    logic [0:2] wl;
    logic       busy;
    logic       done;

    int         n_pass  = 0;
    int         n_total = 0;
    logic       chk_en  = 1'b0;
    logic       abort_at_edge = 1'b0;
    logic [2:0] prev_bl = 3'b000;
    logic [2:0] prev_wl = 3'b000;

    always #5 prog_clk = ~prog_clk;

    memory_bank_config_writer dut (
        .prog_clk    (prog_clk),
        .prog_reset_n(prog_reset_n),
        .start       (start),
        .abort       (abort),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_data    (cfg_data),
        .bl          (bl),
        .wl          (wl),
        .busy        (busy),
        .done        (done)
    );

    // Bit-i views of the ascending line buses.
    function automatic logic [2:0] bl_bits();
        logic [2:0] v;
        for (int i = 0; i < 3; i++) v[i] = bl[i];
        return v;
    endfunction

    function automatic logic [2:0] wl_bits();
        logic [2:0] v;
        for (int i = 0; i < 3; i++) v[i] = wl[i];
        return v;
    endfunction

    // Line-safety checker, active on every test except across the async reset.
    always @(posedge prog_clk) abort_at_edge <= abort;

    always @(negedge prog_clk) begin
        if (chk_en) begin
            n_total++;
            if ($countones(wl_bits()) > 1)
                $display("FAIL wl_onehot: wl=%b required at most one hot", wl_bits());
            else n_pass++;
            n_total++;
            if (wl_bits() != 3'b000 && bl_bits() !== prev_bl)
                $display("FAIL bl_stable_under_wl: bl=%b previous %b with wl=%b", bl_bits(), prev_bl, wl_bits());
            else n_pass++;
            n_total++;
            if (!abort_at_edge && bl_bits() !== prev_bl && wl_bits() !== prev_wl)
                $display("FAIL bl_wl_same_edge: bl %b->%b and wl %b->%b on one edge", prev_bl, bl_bits(), prev_wl, wl_bits());
            else n_pass++;
        end
        prev_bl <= bl_bits();
        prev_wl <= wl_bits();
    end

    // Full three-row load from IDLE. stall = cycles cfg_valid is withheld in row 1's
    // LOAD; start_c = cycle at which a spurious start is pulsed (0 = none).
    // Expected per cycle ce (stall removed): phase p=(ce-1)%5 -> LOAD,SETUP,PULSE,PULSE,HOLD.
    task automatic load_and_check(input int stall, input logic [2:0] d0, input logic [2:0] d1,
                                  input logic [2:0] d2, input int start_c);
        logic [2:0] rows [3];
        int         ce, p, r, nbusy;
        logic [8:0] exp_v, got_v;
        rows  = '{d0, d1, d2};
        nbusy = 0;
        start = 1'b1;
        cfg_valid = 1'b1;
        cfg_data  = d0;
        for (int c = 1; c <= 17 + stall; c++) begin
            @(negedge prog_clk);
            start = (c == start_c);
            if (c <= 5) ce = c;
            else if (c < 6 + stall) ce = 6;
            else ce = c - stall;
            p = (ce - 1) % 5;
            r = (ce - 1) / 5;
            if (ce <= 15)
                exp_v = {1'b1, (p == 0), 1'b0, ((p == 0) ? 3'b000 : rows[r]),
                         ((p == 2 || p == 3) ? (3'b001 << r) : 3'b000)};
            else
                exp_v = {1'b0, 1'b0, 1'b1, 3'b000, 3'b000};
            got_v = {busy, cfg_ready, done, bl_bits(), wl_bits()};
            n_total++;
            if (got_v !== exp_v)
                $display("FAIL load_cycle%0d: busy/ready/done/bl/wl got %b required %b", c, got_v, exp_v);
            else n_pass++;
            if (busy) nbusy++;
            cfg_valid = !(c >= 6 && c < 6 + stall);
            // Outside LOAD offer inverted data so any stray capture shows on bl.
            if (ce <= 15 && p == 0) cfg_data = rows[r];
            else cfg_data = ~rows[(ce <= 15) ? r : 2];
        end
        cfg_valid = 1'b0;
        start     = 1'b0;
        n_total++;
        if (nbusy != 15 + stall)
            $display("FAIL busy_cycles: got %0d required %0d", nbusy, 15 + stall);
        else n_pass++;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge prog_clk);
        n_total++;
        if ({cfg_ready, busy, done, bl_bits(), wl_bits()} !== 9'b0)
            $display("FAIL reset_outputs: got %b required %b", {cfg_ready, busy, done, bl_bits(), wl_bits()}, 9'b0);
        else n_pass++;
        prog_reset_n = 1'b1;
        repeat (3) @(negedge prog_clk);
        n_total++;
        if ({cfg_ready, busy, done, bl_bits(), wl_bits()} !== 9'b0)
            $display("FAIL idle_after_release: got %b required %b", {cfg_ready, busy, done, bl_bits(), wl_bits()}, 9'b0);
        else n_pass++;
        chk_en = 1'b1;
    endtask

    task automatic test_full_load();
        load_and_check(0, 3'b101, 3'b011, 3'b110, 0);
    endtask

    task automatic test_stall();
        load_and_check(4, 3'b011, 3'b110, 3'b001, 0);
    endtask

    task automatic test_abort();
        logic [2:0] rows [3];
        rows = '{3'b110, 3'b011, 3'b101};
        start = 1'b1;
        cfg_valid = 1'b1;
        cfg_data = rows[0];
        for (int c = 1; c <= 9; c++) begin
            @(negedge prog_clk);
            start = 1'b0;
            cfg_data = rows[(c - 1) / 5];
            if (c == 9) begin
                n_total++;
                if ({bl_bits(), wl_bits()} !== {3'b011, 3'b010})
                    $display("FAIL abort_pre_pulse: bl/wl got %b required %b", {bl_bits(), wl_bits()}, 6'b011010);
                else n_pass++;
                abort = 1'b1;
            end
        end
        @(negedge prog_clk);
        abort = 1'b0;
        cfg_valid = 1'b0;
        n_total++;
        if ({cfg_ready, busy, done, bl_bits(), wl_bits()} !== 9'b0)
            $display("FAIL abort_outputs: got %b required %b", {cfg_ready, busy, done, bl_bits(), wl_bits()}, 9'b0);
        else n_pass++;
        @(negedge prog_clk);
        n_total++;
        if ({busy, cfg_ready} !== 2'b00)
            $display("FAIL abort_stays_idle: busy/ready got %b required 00", {busy, cfg_ready});
        else n_pass++;
        load_and_check(0, 3'b100, 3'b010, 3'b001, 0);
    endtask

    task automatic test_async_reset();
        start = 1'b1;
        cfg_valid = 1'b1;
        cfg_data = 3'b111;
        repeat (3) begin
            @(negedge prog_clk);
            start = 1'b0;
        end
        n_total++;
        if (wl_bits() !== 3'b001)
            $display("FAIL reset_pre_pulse: wl got %b required 001", wl_bits());
        else n_pass++;
        chk_en = 1'b0;
        #2 prog_reset_n = 1'b0;
        #1;
        n_total++;
        if ({cfg_ready, busy, done, bl_bits(), wl_bits()} !== 9'b0)
            $display("FAIL async_reset_outputs: got %b required %b", {cfg_ready, busy, done, bl_bits(), wl_bits()}, 9'b0);
        else n_pass++;
        cfg_valid = 1'b0;
        repeat (2) @(negedge prog_clk);
        #2 prog_reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge prog_clk);
            n_total++;
            if ({cfg_ready, busy, done, bl_bits(), wl_bits()} !== 9'b0)
                $display("FAIL post_reset_idle%0d: got %b required %b", c, {cfg_ready, busy, done, bl_bits(), wl_bits()}, 9'b0);
            else n_pass++;
        end
        chk_en = 1'b1;
    endtask

    task automatic test_ignored();
        cfg_valid = 1'b1;
        cfg_data  = 3'b111;
        @(negedge prog_clk);
        cfg_valid = 1'b0;
        n_total++;
        if ({cfg_ready, busy, bl_bits()} !== 5'b0)
            $display("FAIL valid_in_idle: ready/busy/bl got %b required 00000", {cfg_ready, busy, bl_bits()});
        else n_pass++;
        start = 1'b1;
        abort = 1'b1;
        @(negedge prog_clk);
        start = 1'b0;
        abort = 1'b0;
        n_total++;
        if ({cfg_ready, busy} !== 2'b00)
            $display("FAIL start_abort_idle: ready/busy got %b required 00", {cfg_ready, busy});
        else n_pass++;
        load_and_check(0, 3'b010, 3'b111, 3'b100, 7);
    endtask

    task automatic test_back_to_back();
        load_and_check(0, 3'b001, 3'b100, 3'b011, 0);
    endtask

    initial begin
        prog_reset_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        cfg_valid = 1'b0;
        cfg_data = 3'b000;
        test_reset();
        test_full_load();
        test_stall();
        test_abort();
        test_async_reset();
        test_ignored();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, %0d/%0d checks passed so far", n_pass, n_total);
        $fatal(1, "time limit");
    end

endmodule
